// File: rtl/rc5_scan_validate_ctrl.sv
// Scan-driven validation controller sitting between the chip scan pins and the RC5 core.
// Optional build macro: SCAN_PARITY_EN appends an even-parity LSB to the scan-out chain.
module rc5_scan_validate_ctrl #(
    parameter int KEY_W     = 128,
    parameter int DATA_W    = 32,
    parameter int ROUNDS_W  = 5,
    parameter int TIMEOUT_W = 12,
    parameter int KEY_GUARD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic                scan_in,
    input  logic                begin_validate,
    output logic                scan_out,
    output logic                busy,
    output logic [KEY_W-1:0]    core_key,
    output logic [DATA_W-1:0]   core_d_in,
    output logic [ROUNDS_W-1:0] core_num_rounds,
    output logic                core_load_key,
    output logic                core_start_encrypt,
    output logic                core_start_decrypt,
    input  logic                core_key_ready,
    input  logic [DATA_W-1:0]   core_d_out,
    input  logic                core_done
);

    localparam int SI_W    = KEY_W + DATA_W + ROUNDS_W + 3;
`ifdef SCAN_PARITY_EN
    localparam int SO_W    = DATA_W + 4;
`else
    localparam int SO_W    = DATA_W + 3;
`endif
    localparam int RND_LSB = KEY_W + DATA_W;
    localparam int LK_BIT  = KEY_W + DATA_W + ROUNDS_W;
    localparam int ENC_BIT = LK_BIT + 1;
    localparam int DEC_BIT = LK_BIT + 2;
    localparam logic [TIMEOUT_W-1:0] GUARD_CNT = TIMEOUT_W'(KEY_GUARD);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADK, S_WAITK, S_START, S_WAITD, S_CAPT, S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [SI_W-1:0]       r_in_sr;
    logic [SO_W-1:0]       r_out_sr;
    logic [KEY_W-1:0]      r_sh_key;
    logic [DATA_W-1:0]     r_sh_din;
    logic [ROUNDS_W-1:0]   r_sh_rounds;
    logic                  r_sh_enc;
    logic                  r_sh_dec;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic                  r_bv_prev;
    logic                  r_cap_tmo;
    logic                  r_cap_err;
    logic                  r_cap_done;
    logic [DATA_W-1:0]     r_cap_dout;

    logic                  w_edge;
    logic [TIMEOUT_W-1:0]  w_cnt_inc;
    logic                  w_tmo;
    logic                  w_in_wait;
    logic                  w_load;
    logic                  w_enc;
    logic                  w_dec;
    logic                  w_latch;
    logic                  w_l_tmo;
    logic                  w_l_err;
    logic                  w_l_done;
    logic [DATA_W+2:0]     w_cap_word;

    assign w_edge     = begin_validate & ~r_bv_prev;
    assign w_cnt_inc  = r_cnt + 1'b1;
    // Timeout fires on the cycle whose increment would reach all-ones.
    assign w_tmo      = (w_cnt_inc == {TIMEOUT_W{1'b1}});
    assign w_in_wait  = (r_state == S_WAITK) || (r_state == S_WAITD);
    assign w_cap_word = {r_cap_tmo, r_cap_err, r_cap_done, r_cap_dout};

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_enc    = 1'b0;
        w_dec    = 1'b0;
        w_latch  = 1'b0;
        w_l_tmo  = 1'b0;
        w_l_err  = 1'b0;
        w_l_done = 1'b0;
        case (r_state)
            // Shadow loads on this same edge, so the branch reads the chain directly.
            S_IDLE: if (w_edge) w_next = r_in_sr[LK_BIT] ? S_LOADK : S_START;
            S_LOADK: begin
                w_load = 1'b1;
                w_next = S_WAITK;
            end
            S_WAITK: begin
                if (w_tmo) begin
                    w_next   = S_CAPT;
                    w_latch  = 1'b1;
                    w_l_tmo  = 1'b1;
                    w_l_done = core_done;
                end else if ((r_cnt >= GUARD_CNT) && core_key_ready) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                case ({r_sh_dec, r_sh_enc})
                    2'b01: begin
                        w_enc  = 1'b1;
                        w_next = S_WAITD;
                    end
                    2'b10: begin
                        w_dec  = 1'b1;
                        w_next = S_WAITD;
                    end
                    2'b11: begin
                        w_next  = S_CAPT;
                        w_latch = 1'b1;
                        w_l_err = 1'b1;
                    end
                    default: begin
                        w_next  = S_CAPT;
                        w_latch = 1'b1;
                    end
                endcase
            end
            S_WAITD: begin
                if (w_tmo || core_done) begin
                    w_next   = S_CAPT;
                    w_latch  = 1'b1;
                    w_l_tmo  = w_tmo;
                    w_l_done = core_done;
                end
            end
            S_CAPT: w_next = S_HOLD;
            S_HOLD: if (!begin_validate) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_sr     <= '0;
            r_out_sr    <= '0;
            r_sh_key    <= '0;
            r_sh_din    <= '0;
            r_sh_rounds <= '0;
            r_sh_enc    <= 1'b0;
            r_sh_dec    <= 1'b0;
            r_cnt       <= '0;
            r_cap_tmo   <= 1'b0;
            r_cap_err   <= 1'b0;
            r_cap_done  <= 1'b0;
            r_cap_dout  <= '0;
            // A level still high across reset must not count as a fresh edge.
            r_bv_prev   <= begin_validate;
        end else begin
            r_state   <= w_next;
            r_bv_prev <= begin_validate;
            if (scan_en && (r_state == S_IDLE)) r_in_sr <= {r_in_sr[SI_W-2:0], scan_in};
            if ((r_state == S_IDLE) && w_edge) begin
                r_sh_key    <= r_in_sr[KEY_W-1:0];
                r_sh_din    <= r_in_sr[KEY_W +: DATA_W];
                r_sh_rounds <= r_in_sr[RND_LSB +: ROUNDS_W];
                r_sh_enc    <= r_in_sr[ENC_BIT];
                r_sh_dec    <= r_in_sr[DEC_BIT];
            end
            r_cnt <= w_in_wait ? w_cnt_inc : '0;
            if (w_latch) begin
                r_cap_tmo  <= w_l_tmo;
                r_cap_err  <= w_l_err;
                r_cap_done <= w_l_done;
                r_cap_dout <= core_d_out;
            end
            if (r_state == S_CAPT) begin
`ifdef SCAN_PARITY_EN
                r_out_sr <= {w_cap_word, ^w_cap_word};
`else
                r_out_sr <= w_cap_word;
`endif
            end else if (scan_en && ((r_state == S_IDLE) || (r_state == S_HOLD))) begin
                r_out_sr <= {r_out_sr[SO_W-2:0], 1'b0};
            end
        end
    end

    assign scan_out           = r_out_sr[SO_W-1];
    assign busy               = (r_state != S_IDLE) && (r_state != S_HOLD);
    assign core_key           = r_sh_key;
    assign core_d_in          = r_sh_din;
    assign core_num_rounds    = r_sh_rounds;
    assign core_load_key      = w_load;
    assign core_start_encrypt = w_enc;
    assign core_start_decrypt = w_dec;

endmodule

// File: tb/tb_rc5_scan_validate_ctrl.sv
// Scoreboard bench for rc5_scan_validate_ctrl; honours SCAN_PARITY_EN like the design.
module tb_rc5_scan_validate_ctrl;

    localparam int KEY_W     = 128;
    localparam int DATA_W    = 32;
    localparam int ROUNDS_W  = 5;
    localparam int TIMEOUT_W = 4;
    localparam int KEY_GUARD = 2;
    localparam int SI_W      = KEY_W + DATA_W + ROUNDS_W + 3;
`ifdef SCAN_PARITY_EN
    localparam int SO_W      = DATA_W + 4;
`else
    localparam int SO_W      = DATA_W + 3;
`endif
    localparam logic [1:0] EV_HOLD = 2'd0;
    localparam logic [1:0] EV_LOAD = 2'd1;
    localparam logic [1:0] EV_ENC  = 2'd2;
    localparam logic [1:0] EV_DEC  = 2'd3;

    localparam logic [KEY_W-1:0]  KEY1   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [DATA_W-1:0] PT1    = 32'hD87FAB42;
    localparam logic [DATA_W-1:0] CT1    = 32'h3C8E5A17;
    localparam logic [KEY_W-1:0]  KEY5   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [DATA_W-1:0] PT5    = 32'h01234567;

    // clock / reset / DUT
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_en = 1'b0;
    logic scan_in = 1'b0;
    logic begin_validate = 1'b0;
    logic scan_out, busy;
    logic [KEY_W-1:0]    core_key;
    logic [DATA_W-1:0]   core_d_in;
    logic [ROUNDS_W-1:0] core_num_rounds;
    logic core_load_key, core_start_encrypt, core_start_decrypt;
    logic core_key_ready = 1'b1;
    logic [DATA_W-1:0] core_d_out = '0;
    logic core_done = 1'b0;

    always #5 clk = ~clk;

    rc5_scan_validate_ctrl #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .ROUNDS_W(ROUNDS_W),
        .TIMEOUT_W(TIMEOUT_W), .KEY_GUARD(KEY_GUARD)
    ) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .begin_validate(begin_validate), .scan_out(scan_out), .busy(busy),
        .core_key(core_key), .core_d_in(core_d_in), .core_num_rounds(core_num_rounds),
        .core_load_key(core_load_key), .core_start_encrypt(core_start_encrypt),
        .core_start_decrypt(core_start_decrypt), .core_key_ready(core_key_ready),
        .core_d_out(core_d_out), .core_done(core_done)
    );

    // core model: fixed-latency done pulse, stuck-done option
    int   cyc = 0;
    int   edge_cyc = 0;
    int   mdl_lat = 3;
    logic mdl_stuck = 1'b0;
    int   m_dcnt = 0;
    logic [DATA_W-1:0] m_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_dcnt    <= 0;
            core_done <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (core_start_encrypt || core_start_decrypt) begin
                m_dcnt <= mdl_lat;
                m_res  <= core_start_encrypt ? ((core_d_in == PT1) ? CT1 : ~core_d_in) : PT1;
            end else if (m_dcnt != 0) begin
                m_dcnt <= m_dcnt - 1;
                if (m_dcnt == 1 && !mdl_stuck) begin
                    core_done  <= 1'b1;
                    core_d_out <= m_res;
                end
            end
        end
    end

    // scoreboard
    int n_cmp = 0;
    int n_fail = 0;
    logic [9:0]      exp_q[$];
    logic [SO_W-1:0] exp_res_q[$];
    logic [SO_W-1:0] act_res_q[$];

    function automatic logic [9:0] ev(input logic [1:0] c, input int d);
        return {c, 8'(d)};
    endfunction

    function automatic logic [SO_W-1:0] res(input logic t, input logic e, input logic d,
                                           input logic [DATA_W-1:0] v);
        logic [DATA_W+2:0] w;
        w = {t, e, d, v};
`ifdef SCAN_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    function automatic logic [SI_W-1:0] mk_si(input logic dec, input logic enc, input logic ld,
                                             input logic [ROUNDS_W-1:0] r,
                                             input logic [DATA_W-1:0] d,
                                             input logic [KEY_W-1:0] k);
        return {dec, enc, ld, r, d, k};
    endfunction

    task automatic got_event(input logic [9:0] a);
        logic [9:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected act=%h (code/delta) exp=none", a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event: act=%h exp=%h (code/delta)", a, e);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: act=%h exp=%h", nm, a, e);
        end
    endtask

    // monitor
    initial begin
        logic prev_busy;
        logic [SO_W-1:0] a, e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (core_load_key)      got_event(ev(EV_LOAD, cyc - edge_cyc));
            if (core_start_encrypt) got_event(ev(EV_ENC,  cyc - edge_cyc));
            if (core_start_decrypt) got_event(ev(EV_DEC,  cyc - edge_cyc));
            if (prev_busy && !busy) got_event(ev(EV_HOLD, cyc - edge_cyc));
            prev_busy = busy;
            while (act_res_q.size() > 0) begin
                a = act_res_q.pop_front();
                n_cmp++;
                if (exp_res_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scan_out word: unexpected act=%h", a);
                end else begin
                    e = exp_res_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL scan_out word: act=%h exp=%h", a, e);
                    end
                end
            end
        end
    end

    // driver tasks (all start and end on a negedge)
    task automatic shift_in(input logic [SI_W-1:0] v);
        for (int i = SI_W - 1; i >= 0; i--) begin
            scan_in = v[i];
            scan_en = 1'b1;
            @(negedge clk);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic read_out();
        logic [SO_W-1:0] w;
        for (int i = SO_W - 1; i >= 0; i--) begin
            w[i]    = scan_out;
            scan_en = 1'b1;
            @(negedge clk);
        end
        scan_en = 1'b0;
        act_res_q.push_back(w);
    endtask

    task automatic start_run();
        begin_validate = 1'b1;
        edge_cyc = cyc;
    endtask

    task automatic wait_hold();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL hold wait: busy still 1 after 80 cycles, exp 0");
        end
    endtask

    task automatic end_run();
        begin_validate = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // reset state
        chk("reset busy", KEY_W'(busy), '0);
        chk("reset core_key", core_key, '0);
        chk("reset core_d_in", KEY_W'(core_d_in), '0);
        chk("reset core_num_rounds", KEY_W'(core_num_rounds), '0);
        exp_res_q.push_back('0);
        read_out();

        // 1: load + encrypt; key_ready already high so only the guard delays the start
        exp_q.push_back(ev(EV_LOAD, 1));
        exp_q.push_back(ev(EV_ENC, 5));
        exp_q.push_back(ev(EV_HOLD, 11));
        exp_res_q.push_back(res(1'b0, 1'b0, 1'b1, CT1));
        shift_in(mk_si(1'b0, 1'b1, 1'b1, 5'd31, PT1, KEY1));
        start_run();
        @(negedge clk);
        chk("t1 core_key", core_key, KEY1);
        chk("t1 core_d_in", KEY_W'(core_d_in), KEY_W'(PT1));
        chk("t1 core_num_rounds", KEY_W'(core_num_rounds), KEY_W'(5'd31));
        wait_hold();
        read_out();
        end_run();

        // 2: decrypt without key load
        exp_q.push_back(ev(EV_DEC, 1));
        exp_q.push_back(ev(EV_HOLD, 7));
        exp_res_q.push_back(res(1'b0, 1'b0, 1'b1, PT1));
        shift_in(mk_si(1'b1, 1'b0, 1'b0, 5'd31, PT1, KEY1));
        start_run();
        wait_hold();
        read_out();
        end_run();

        // 3: both start bits -> error, no pulse
        exp_q.push_back(ev(EV_HOLD, 3));
        exp_res_q.push_back(res(1'b0, 1'b1, 1'b0, PT1));
        shift_in(mk_si(1'b1, 1'b1, 1'b0, 5'd31, PT1, KEY1));
        start_run();
        wait_hold();
        read_out();
        end_run();

        // 4: done stuck low -> WAITD timeout after 15 cycles
        mdl_stuck = 1'b1;
        exp_q.push_back(ev(EV_DEC, 1));
        exp_q.push_back(ev(EV_HOLD, 18));
        exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, PT1));
        shift_in(mk_si(1'b1, 1'b0, 1'b0, 5'd31, PT1, KEY1));
        start_run();
        wait_hold();
        read_out();
        end_run();
        mdl_stuck = 1'b0;

        // 4b: key_ready never rises -> WAITK timeout
        core_key_ready = 1'b0;
        exp_q.push_back(ev(EV_LOAD, 1));
        exp_q.push_back(ev(EV_HOLD, 18));
        exp_res_q.push_back(res(1'b1, 1'b0, 1'b0, PT1));
        shift_in(mk_si(1'b0, 1'b1, 1'b1, 5'd31, PT1, KEY1));
        start_run();
        wait_hold();
        read_out();
        end_run();
        core_key_ready = 1'b1;

        // 5: scan activity while busy must not touch either chain
        mdl_lat = 10;
        exp_q.push_back(ev(EV_ENC, 1));
        exp_q.push_back(ev(EV_HOLD, 14));
        exp_res_q.push_back(res(1'b0, 1'b0, 1'b1, ~PT5));
        shift_in(mk_si(1'b0, 1'b1, 1'b0, 5'd12, PT5, KEY5));
        start_run();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            scan_en = 1'($urandom_range(1, 0));
            scan_in = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
        wait_hold();
        read_out();
        end_run();

        // 5b: rerun from the untouched chain, then reset mid-WAITD
        exp_q.push_back(ev(EV_ENC, 1));
        exp_q.push_back(ev(EV_HOLD, 5));
        start_run();
        @(negedge clk);
        chk("t5 core_key kept", core_key, KEY5);
        chk("t5 core_d_in kept", KEY_W'(core_d_in), KEY_W'(PT5));
        chk("t5 rounds kept", KEY_W'(core_num_rounds), KEY_W'(5'd12));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", KEY_W'(busy), '0);
        chk("rst core_key", core_key, '0);
        chk("rst core_d_in", KEY_W'(core_d_in), '0);
        chk("rst core_num_rounds", KEY_W'(core_num_rounds), '0);
        chk("rst pulses", KEY_W'({core_load_key, core_start_encrypt, core_start_decrypt}), '0);
        chk("rst scan_out", KEY_W'(scan_out), '0);
        repeat (20) @(negedge clk);
        exp_res_q.push_back('0);
        read_out();
        begin_validate = 1'b0;
        repeat (4) @(negedge clk);

        chk("pending events", KEY_W'(exp_q.size()), '0);
        chk("pending results", KEY_W'(exp_res_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
